ps2_keycode_decoder: RTL and testbench

- Sits directly upstream of the VGA text display.
- Consumes the raw PS/2 scan-code byte stream from the PS/2 receiver, decodes make/break/extended prefixes and tracks shift state, then buffers decoded make codes in a small FIFO.
- Presents each make code on a 32-bit keycode word with a stretched flag strobe. The strobe is stretched so a consumer that samples on the rising edge of flag sees exactly one edge per key press.

---
 rtl/ps2_keycode_decoder.sv | 209 ++++++++++++++++++++
 tb/tb_ps2_keycode_decoder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keycode_decoder.sv
//------------------------------------------------------------------------------
// Module  : ps2_keycode_decoder
// Brief   : PS/2 scan-code decoder with shift tracking, keycode FIFO and
//           stretched flag strobe for the VGA text display.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ps2_keycode_decoder #(
  parameter int FIFO_DEPTH    = 4,
  parameter int FLAG_CYCLES   = 16,
  parameter int REPEAT_FILTER = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    rx_byte,
  input  logic                          rx_valid,
  output logic [31:0]                   keycode,
  output logic                          flag,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FLAG_CYCLES) + 1;
  localparam logic [AW:0]   c_depth    = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] c_cnt_last = CW'(FLAG_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, EXT, BREAK, EXT_BREAK} dec_state_t;
  typedef enum logic [1:0] {IDLE_OUT, HIGH, LOW} out_state_t;

  dec_state_t      r_dec_state;
  out_state_t      r_out_state;
  logic            r_shift;
  logic [7:0]      r_last_make;
  logic            r_push_vld;
  logic            r_push_ext;
  logic [7:0]      r_push_code;
  logic [9:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            r_overflow;
  logic [31:0]     r_keycode;
  logic            r_flag;
  logic [CW-1:0]   r_cnt;

  logic            w_noise;
  logic            w_shift_code;
  logic            w_repeat;
  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_bypass;
  logic            w_fifo_wr;
  logic            w_drop;
  logic [9:0]      w_head;
  logic [9:0]      w_push_word;

  assign w_noise      = (rx_byte == 8'hAA) || (rx_byte == 8'hFA) || (rx_byte == 8'hFE) ||
                        (rx_byte == 8'hEE) || (rx_byte == 8'h00) || (rx_byte == 8'hFF);
  assign w_shift_code = (rx_byte == 8'h12) || (rx_byte == 8'h59);
  assign w_repeat     = (REPEAT_FILTER != 0) && (rx_byte == r_last_make);

  // Decoder: a completed make is staged for one cycle, then pushed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dec_state <= IDLE;
      r_shift     <= 1'b0;
      r_last_make <= 8'h00;
      r_push_vld  <= 1'b0;
      r_push_ext  <= 1'b0;
      r_push_code <= 8'h00;
    end else begin
      r_push_vld <= 1'b0;
      if (rx_valid) begin
        case (r_dec_state)
          IDLE: begin
            if (rx_byte == 8'hE0) begin
              r_dec_state <= EXT;
            end else if (rx_byte == 8'hF0) begin
              r_dec_state <= BREAK;
            end else if (w_noise) begin
              r_dec_state <= IDLE;
            end else if (w_shift_code) begin
              r_shift <= 1'b1;
            end else if (!w_repeat) begin
              r_last_make <= rx_byte;
              r_push_vld  <= 1'b1;
              r_push_ext  <= 1'b0;
              r_push_code <= rx_byte;
            end
          end
          EXT: begin
            if (rx_byte == 8'hF0) begin
              r_dec_state <= EXT_BREAK;
            end else if (rx_byte == 8'hE0) begin
              r_dec_state <= EXT;
            end else begin
              r_dec_state <= IDLE;
              if (rx_byte != 8'h12 && !w_repeat) begin
                r_last_make <= rx_byte;
                r_push_vld  <= 1'b1;
                r_push_ext  <= 1'b1;
                r_push_code <= rx_byte;
              end
            end
          end
          BREAK: begin
            if (rx_byte != 8'hF0 && rx_byte != 8'hE0) begin
              r_dec_state <= IDLE;
              if (w_shift_code)
                r_shift <= 1'b0;
              else if (rx_byte == r_last_make)
                r_last_make <= 8'h00;
            end
          end
          default: begin
            if (rx_byte != 8'hF0 && rx_byte != 8'hE0) begin
              r_dec_state <= IDLE;
              if (rx_byte == r_last_make)
                r_last_make <= 8'h00;
            end
          end
        endcase
      end
    end
  end

  // An idle output stage with an empty FIFO takes the staged make directly.
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == c_depth);
  assign w_pop       = (r_out_state == IDLE_OUT) && !w_empty;
  assign w_bypass    = (r_out_state == IDLE_OUT) && w_empty && r_push_vld;
  assign w_fifo_wr   = r_push_vld && !w_bypass && (!w_full || w_pop);
  assign w_drop      = r_push_vld && !w_bypass && w_full && !w_pop;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_push_word = {r_shift, r_push_ext, r_push_code};

  always_ff @(posedge clk) begin
    if (w_fifo_wr)
      r_mem[r_wr_ptr] <= w_push_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_fifo_wr)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_fifo_wr && !w_pop)
        r_count <= r_count + 1'b1;
      else if (!w_fifo_wr && w_pop)
        r_count <= r_count - 1'b1;
      if (w_drop)
        r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_state <= IDLE_OUT;
      r_keycode   <= '0;
      r_flag      <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_out_state)
        IDLE_OUT: begin
          r_cnt <= '0;
          if (w_pop || w_bypass) begin
            r_keycode   <= {22'b0, (w_pop ? w_head : w_push_word)};
            r_flag      <= 1'b1;
            r_out_state <= HIGH;
          end
        end
        HIGH: begin
          if (r_cnt == c_cnt_last) begin
            r_cnt       <= '0;
            r_flag      <= 1'b0;
            r_out_state <= LOW;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          if (r_cnt == c_cnt_last) begin
            r_cnt       <= '0;
            r_out_state <= IDLE_OUT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign keycode    = r_keycode;
  assign flag       = r_flag;
  assign overflow   = r_overflow;
  assign fifo_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_ps2_keycode_decoder.sv
//------------------------------------------------------------------------------
// Module  : tb_ps2_keycode_decoder
// Brief   : Directed bench for ps2_keycode_decoder (filtered and unfiltered).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ps2_keycode_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_valid = 1'b0;
  logic [31:0] keycode, keycode_nf;
  logic        flag, flag_nf;
  logic        overflow, overflow_nf;
  logic [2:0]  fifo_count, fifo_count_nf;

  int n_checks = 0;
  int n_fails  = 0;

  int          pulses = 0;
  int          pulses_nf = 0;
  int          hi_cnt = 0;
  int          max_cnt = 0;
  logic        flag_q = 1'b0;
  logic        flag_nf_q = 1'b0;
  logic [31:0] kc_q[$];
  int          hi_q[$];

  always #5 clk = ~clk;

  ps2_keycode_decoder #(.FIFO_DEPTH(4), .FLAG_CYCLES(16), .REPEAT_FILTER(1)) dut (
    .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .keycode(keycode), .flag(flag), .overflow(overflow), .fifo_count(fifo_count)
  );

  ps2_keycode_decoder #(.FIFO_DEPTH(4), .FLAG_CYCLES(16), .REPEAT_FILTER(0)) dut_nf (
    .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .keycode(keycode_nf), .flag(flag_nf), .overflow(overflow_nf), .fifo_count(fifo_count_nf)
  );

  // Pulse monitor: counts rising flag edges, captures keycode, measures high time.
  always @(negedge clk) begin
    if (flag && !flag_q) begin
      pulses <= pulses + 1;
      kc_q.push_back(keycode);
    end
    if (flag)
      hi_cnt <= hi_cnt + 1;
    else if (flag_q) begin
      hi_q.push_back(hi_cnt);
      hi_cnt <= 0;
    end
    if (flag_nf && !flag_nf_q)
      pulses_nf <= pulses_nf + 1;
    if (int'(fifo_count) > max_cnt)
      max_cnt <= int'(fifo_count);
    flag_q    <= flag;
    flag_nf_q <= flag_nf;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; holds the byte valid for exactly one cycle.
  task automatic send(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    cycles(1);
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    cycles(1);
  endtask

  int p0, p0_nf, k0;

  initial begin
    cycles(2);
    check("reset_flag", {31'b0, flag}, 32'h0);
    check("reset_keycode", keycode, 32'h0);
    check("reset_overflow", {31'b0, overflow}, 32'h0);
    check("reset_count", {29'b0, fifo_count}, 32'h0);
    reset = 1'b0;
    cycles(1);

    // Single make with latency and pulse-width checks
    p0 = pulses; k0 = kc_q.size();
    send(8'h1C);
    check("lat_n1_flag", {31'b0, flag}, 32'h0);
    cycles(1);
    check("lat_n2_flag", {31'b0, flag}, 32'h1);
    check("lat_n2_keycode", keycode, 32'h0000_001C);
    send(8'hF0);
    send(8'h1C);
    cycles(60);
    check("single_pulses", pulses - p0, 1);
    check("single_high_len", hi_q[hi_q.size()-1], 16);
    check("single_keycode_hold", keycode, 32'h0000_001C);
    check("single_overflow", {31'b0, overflow}, 32'h0);

    // Extended make with shift held, then shift released
    do_reset();
    p0 = pulses; k0 = kc_q.size();
    send(8'h12); send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hF0); send(8'h12);
    cycles(40);
    send(8'h1C);
    cycles(40);
    check("ext_pulses", pulses - p0, 2);
    check("ext_shift_kc", kc_q[k0], 32'h0000_0375);
    check("ext_after_kc", kc_q[k0+1], 32'h0000_001C);

    // Typematic repeat filter vs unfiltered instance
    do_reset();
    p0 = pulses; p0_nf = pulses_nf; k0 = kc_q.size();
    send(8'h23); send(8'h23); send(8'h23);
    send(8'hF0); send(8'h23);
    send(8'h23);
    cycles(150);
    check("rep_pulses", pulses - p0, 2);
    check("rep_kc0", kc_q[k0], 32'h0000_0023);
    check("rep_kc1", kc_q[k0+1], 32'h0000_0023);
    check("rep_nf_pulses", pulses_nf - p0_nf, 4);

    // FIFO overflow with six back-to-back makes
    do_reset();
    p0 = pulses; k0 = kc_q.size();
    send(8'h16); send(8'h1E); send(8'h26);
    send(8'h25); send(8'h2E); send(8'h36);
    check("ovf_before", {31'b0, overflow}, 32'h0);
    cycles(1);
    check("ovf_set", {31'b0, overflow}, 32'h1);
    check("ovf_count", {29'b0, fifo_count}, 32'h4);
    cycles(175);
    check("ovf_pulses", pulses - p0, 5);
    check("ovf_kc0", kc_q[k0],   32'h0000_0016);
    check("ovf_kc1", kc_q[k0+1], 32'h0000_001E);
    check("ovf_kc2", kc_q[k0+2], 32'h0000_0026);
    check("ovf_kc3", kc_q[k0+3], 32'h0000_0025);
    check("ovf_kc4", kc_q[k0+4], 32'h0000_002E);
    check("ovf_high_len", hi_q[hi_q.size()-1], 16);
    check("ovf_sticky", {31'b0, overflow}, 32'h1);
    check("ovf_drained", {29'b0, fifo_count}, 32'h0);
    check("ovf_max_count", {31'b0, (max_cnt <= 4)}, 32'h1);

    // Noise bytes are ignored and the decoder stays in IDLE
    do_reset();
    p0 = pulses; k0 = kc_q.size();
    send(8'hAA); send(8'hFA); send(8'hFE); send(8'hEE);
    send(8'h45);
    cycles(40);
    send(8'h1C);
    cycles(40);
    check("noise_pulses", pulses - p0, 2);
    check("noise_kc", kc_q[k0], 32'h0000_0045);
    check("noise_next_kc", kc_q[k0+1], 32'h0000_001C);

    // Asynchronous reset in the middle of a HIGH period
    do_reset();
    send(8'h16); send(8'h1E); send(8'h26);
    cycles(5);
    check("mid_flag_high", {31'b0, flag}, 32'h1);
    check("mid_count", {29'b0, fifo_count}, 32'h2);
    #2;
    reset = 1'b1;
    #1;
    check("arst_flag", {31'b0, flag}, 32'h0);
    check("arst_keycode", keycode, 32'h0);
    check("arst_count", {29'b0, fifo_count}, 32'h0);
    cycles(2);
    reset = 1'b0;
    cycles(1);
    send(8'h16);
    cycles(1);
    check("post_rst_flag", {31'b0, flag}, 32'h1);
    check("post_rst_kc", keycode, 32'h0000_0016);
    check("post_rst_ovf", {31'b0, overflow}, 32'h0);
    cycles(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
